// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default widths and Gray/binary pointer conversions.
// Conversions work on a zero-extended 32-bit word; callers cast the result to their pointer width.
package fifo_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;
  localparam int CODE_W     = 32;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b[CODE_W-1] = g[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wr_2_rd_sync.sv
// Two-flop synchronizer bringing the Gray write pointer into the read clock domain.
module wr_2_rd_sync #(
  parameter int Width = 9
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [Width-1:0] i_ptr_gray,
  output logic [Width-1:0] o_ptr_sync
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_ptr_gray;
      r_sync <= r_meta;
    end
  end

  assign o_ptr_sync = r_sync;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointer, memory read issue,
// registered read data and empty/almost-empty/level/underflow status.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int Addr_Width          = ADDR_WIDTH,
  parameter int Data_Width          = DATA_WIDTH,
  parameter int Almost_Empty_Thresh = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_en,
  input  logic [Addr_Width:0]   wr_ptr_gray,
  input  logic [Data_Width-1:0] mem_rd_data,
  output logic                  mem_rd_en,
  output logic [Addr_Width-1:0] mem_rd_addr,
  output logic [Addr_Width:0]   rd_ptr_gray,
  output logic [Data_Width-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [Addr_Width:0]   rd_level,
  output logic                  underflow
);

  localparam int PW = Addr_Width + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(Almost_Empty_Thresh);

  // Consumer handshake: a read is taken in any cycle where rd_en is high and the
  // registered empty is low; its data appears with a single-cycle rd_valid two
  // edges later. rd_en while empty is dropped and reported on underflow.

  logic [PW-1:0] w_wr_ptr_sync;
  logic [PW-1:0] w_wr_bin_sync;
  logic [PW-1:0] w_rd_ptr_bin_next;
  logic [PW-1:0] w_rd_gray_next;
  logic [PW-1:0] w_level_next;
  logic          w_accept;

  logic [PW-1:0] r_rd_ptr_bin;
  logic          r_stage1;

  wr_2_rd_sync #(
    .Width(PW)
  ) u_wr_2_rd_sync (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .i_ptr_gray(wr_ptr_gray),
    .o_ptr_sync(w_wr_ptr_sync)
  );

  assign w_wr_bin_sync     = PW'(gray2bin(CODE_W'(w_wr_ptr_sync)));
  assign w_accept          = rd_en && !empty;
  assign w_rd_ptr_bin_next = r_rd_ptr_bin + {{Addr_Width{1'b0}}, w_accept};
  assign w_rd_gray_next    = PW'(bin2gray(CODE_W'(w_rd_ptr_bin_next)));
  // Modular difference stays correct across the pointer wrap.
  assign w_level_next      = w_wr_bin_sync - w_rd_ptr_bin_next;

  assign mem_rd_en   = w_accept;
  assign mem_rd_addr = r_rd_ptr_bin[Addr_Width-1:0];

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_rd_ptr_bin <= '0;
      rd_ptr_gray  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      underflow    <= 1'b0;
      r_stage1     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      r_rd_ptr_bin <= w_rd_ptr_bin_next;
      rd_ptr_gray  <= w_rd_gray_next;
      empty        <= (w_rd_gray_next == w_wr_ptr_sync);
      almost_empty <= (w_level_next <= AE_THRESH);
      rd_level     <= w_level_next;
      underflow    <= rd_en && empty;
      r_stage1     <= w_accept;
      rd_valid     <= r_stage1;
      if (r_stage1) begin
        rd_data <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a small write-side model, a 1-cycle
// synchronous memory and an in-order data scoreboard.
module tb_fifo_rd_ctrl;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          rd_rst;
  logic          rd_en;
  logic [PW-1:0] wr_ptr_gray;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [PW-1:0] rd_ptr_gray;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          almost_empty;
  logic [PW-1:0] rd_level;
  logic          underflow;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int snap_valid;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem[0:(1<<AW)-1];
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] prev_gray = '0;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(
    .Addr_Width         (AW),
    .Data_Width         (DW),
    .Almost_Empty_Thresh(2)
  ) dut (
    .rd_clk      (clk),
    .rd_rst      (rd_rst),
    .rd_en       (rd_en),
    .wr_ptr_gray (wr_ptr_gray),
    .mem_rd_data (mem_rd_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .rd_ptr_gray (rd_ptr_gray),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .almost_empty(almost_empty),
    .rd_level    (rd_level),
    .underflow   (underflow)
  );

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  function automatic logic [PW-1:0] tb_gray(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wr_bin[AW-1:0]] = d;
    wr_bin      = wr_bin + 1'b1;
    wr_ptr_gray = tb_gray(wr_bin);
    exp_q.push_back(d);
  endtask

  task automatic wait_not_empty(input int max_cycles);
    for (int k = 0; k < max_cycles && empty !== 1'b0; k++) tick();
    chk("wait_not_empty", {31'b0, empty}, 32'd0);
  endtask

  // Scoreboard and Gray single-bit-step monitor.
  always @(negedge clk) begin
    if (rd_rst === 1'b1) begin
      prev_gray = rd_ptr_gray;
    end else if (rd_ptr_gray !== prev_gray) begin
      chk("gray_one_bit_step", $countones(rd_ptr_gray ^ prev_gray), 32'd1);
      prev_gray = rd_ptr_gray;
    end
    if (rd_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 32'd1, 32'd0);
      else chk("rd_data_order", {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
    end
  end

  initial begin
    rd_rst = 1'b1; rd_en = 1'b0; wr_bin = '0; rd_bin = '0; wr_ptr_gray = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    repeat (2) tick();
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_almost_empty", {31'b0, almost_empty}, 32'd1);
    chk("rst_rd_ptr_gray", {28'b0, rd_ptr_gray}, 32'd0);
    chk("rst_rd_level", {28'b0, rd_level}, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_underflow", {31'b0, underflow}, 32'd0);
    chk("rst_rd_data", {24'b0, rd_data}, 32'd0);
    rd_rst = 1'b0;

    // Basic read: three words become visible two edges after the pointer moves.
    write_word(8'hA1); write_word(8'hA2); write_word(8'hA3);
    tick(); chk("basic_empty_e0", {31'b0, empty}, 32'd1);
    tick(); chk("basic_empty_e1", {31'b0, empty}, 32'd1);
    chk("basic_level_e1", {28'b0, rd_level}, 32'd0);
    tick(); chk("basic_empty_e2", {31'b0, empty}, 32'd0);
    chk("thr_level_3", {28'b0, rd_level}, 32'd3);
    chk("thr_ae_level_3", {31'b0, almost_empty}, 32'd0);
    rd_en = 1'b1;
    #1;
    chk("basic_mem_rd_en", {31'b0, mem_rd_en}, 32'd1);
    chk("basic_mem_addr0", {29'b0, mem_rd_addr}, 32'd0);
    tick();
    chk("thr_level_2", {28'b0, rd_level}, 32'd2);
    chk("thr_ae_level_2", {31'b0, almost_empty}, 32'd1);
    chk("basic_valid_lat1", {31'b0, rd_valid}, 32'd0);
    chk("basic_mem_addr1", {29'b0, mem_rd_addr}, 32'd1);
    tick();
    chk("basic_valid_lat2", {31'b0, rd_valid}, 32'd1);
    chk("basic_first_data", {24'b0, rd_data}, 32'hA1);
    tick();
    rd_en = 1'b0;
    rd_bin = rd_bin + 3'd3;
    chk("basic_empty_after", {31'b0, empty}, 32'd1);
    chk("basic_level_after", {28'b0, rd_level}, 32'd0);
    chk("basic_rd_ptr_gray", {28'b0, rd_ptr_gray}, {28'b0, tb_gray(rd_bin)});
    repeat (3) tick();
    chk("basic_valid_count", n_valid, 32'd3);
    chk("basic_queue_drained", exp_q.size(), 32'd0);

    // Underflow: read request while empty is dropped.
    rd_en = 1'b1;
    #1;
    chk("uf_mem_rd_en", {31'b0, mem_rd_en}, 32'd0);
    tick();
    chk("uf_pulse", {31'b0, underflow}, 32'd1);
    chk("uf_gray_hold", {28'b0, rd_ptr_gray}, {28'b0, tb_gray(rd_bin)});
    rd_en = 1'b0;
    tick();
    chk("uf_pulse_end", {31'b0, underflow}, 32'd0);
    chk("uf_gray_hold2", {28'b0, rd_ptr_gray}, {28'b0, tb_gray(rd_bin)});

    // Wrap-around: 20 write/read pairs walk the pointer past 15 -> 0.
    for (int i = 0; i < 20; i++) begin
      write_word(8'h30 + 8'(i));
      wait_not_empty(6);
      rd_en = 1'b1;
      #1;
      chk("wrap_mem_addr", {29'b0, mem_rd_addr}, {29'b0, rd_bin[AW-1:0]});
      tick();
      rd_en = 1'b0;
      rd_bin = rd_bin + 1'b1;
    end
    repeat (4) tick();
    chk("wrap_valid_count", n_valid, 32'd23);
    chk("wrap_queue_drained", exp_q.size(), 32'd0);
    chk("wrap_rd_ptr_gray", {28'b0, rd_ptr_gray}, {28'b0, tb_gray(rd_bin)});
    chk("wrap_empty", {31'b0, empty}, 32'd1);

    // Reset in the middle of a four-word burst.
    write_word(8'hB0); write_word(8'hB1); write_word(8'hB2); write_word(8'hB3);
    wait_not_empty(6);
    rd_en = 1'b1;
    repeat (2) tick();
    rd_rst = 1'b1; wr_bin = '0; wr_ptr_gray = '0; rd_bin = '0;
    tick();
    rd_en = 1'b0;
    exp_q.delete();
    snap_valid = n_valid;
    chk("mid_rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_almost_empty", {31'b0, almost_empty}, 32'd1);
    chk("mid_rst_rd_ptr_gray", {28'b0, rd_ptr_gray}, 32'd0);
    chk("mid_rst_rd_level", {28'b0, rd_level}, 32'd0);
    chk("mid_rst_rd_data", {24'b0, rd_data}, 32'd0);
    chk("mid_rst_underflow", {31'b0, underflow}, 32'd0);
    tick();
    rd_rst = 1'b0;
    repeat (4) tick();
    chk("mid_rst_no_valid", n_valid, snap_valid);
    chk("mid_rst_still_empty", {31'b0, empty}, 32'd1);

    // Post-reset traffic restarts from address 0.
    write_word(8'hC0); write_word(8'hC1);
    wait_not_empty(6);
    rd_en = 1'b1;
    repeat (2) tick();
    rd_en = 1'b0;
    rd_bin = rd_bin + 2'd2;
    repeat (4) tick();
    chk("post_rst_valid_count", n_valid, snap_valid + 2);
    chk("post_rst_queue_drained", exp_q.size(), 32'd0);
    chk("post_rst_rd_ptr_gray", {28'b0, rd_ptr_gray}, {28'b0, tb_gray(rd_bin)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
